// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor.
// WIDTH-bit operands are processed DIGIT bits per clock through a ripple of
// full-add or full-subtract cells. A registered carry/borrow links successive
// digits. Result and flags are published only when the last digit completes.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_mode;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_s;
    logic [WIDTH-1:0] w_res_next;
    logic             w_ovf;
    logic             w_last;

    assign w_c[0] = r_carry;
    assign w_last = (r_state == S_RUN) && (r_cnt == LAST);

    // One full-add / full-subtract cell per bit of the digit, rippling the carry/borrow.
    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_cell
            logic w_x;
            logic w_y;
            assign w_x       = r_a_sh[gi];
            assign w_y       = r_b_sh[gi];
            assign w_s[gi]   = w_x ^ w_y ^ w_c[gi];
            assign w_c[gi+1] = r_mode ? ((~w_x & w_y) | ((~w_x | w_y) & w_c[gi]))
                                      : ((w_x & w_y) | ((w_x ^ w_y) & w_c[gi]));
        end
    endgenerate

    // Partial result accumulates from the MSB side; with a single digit per
    // operation there is nothing to accumulate and the cells give the result directly.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign w_res_next = w_s;
        end else begin : g_part
            logic [WIDTH-DIGIT-1:0] r_res_sh;
            assign w_res_next = {w_s, r_res_sh};

            // Shift each finished digit into the partial-result register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_res_sh <= '0;
                end else if (r_state == S_IDLE && start) begin
                    r_res_sh <= '0;
                end else if (r_state == S_RUN) begin
                    r_res_sh <= w_res_next[WIDTH-1:DIGIT];
                end
            end
        end
    endgenerate

    // Signed overflow uses the sign bits captured at start and the completed result.
    assign w_ovf = r_mode ? ((r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb))
                          : ((r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb));

    // Control FSM: capture operands on start, step one digit per cycle, publish on the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_mode   <= 1'b0;
            r_carry  <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_mode  <= mode;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= r_a_sh >> DIGIT;
                    r_b_sh  <= r_b_sh >> DIGIT;
                    r_carry <= w_c[DIGIT];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_res_next;
                        r_cout   <= w_c[DIGIT];
                        r_ovf    <= w_ovf;
                        r_zero   <= (w_res_next == '0);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: four configurations (8/1, 8/4, 16/8, 8/8) share
// one clock and reset. Stimulus pushes expected completions into per-config
// queues; a negedge monitor pops and compares whenever done is seen.
module tb_serial_addsub;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        z;
        int          due;
    } exp_t;

    localparam int W_OF[4] = '{8, 8, 16, 8};
    localparam int N_OF[4] = '{8, 2, 2, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic       start0, start1, start2, start3;
    logic       mode0, mode1, mode2, mode3;
    logic [7:0] a0, b0, a1, b1, a3, b3;
    logic [15:0] a2, b2;
    logic       busy0, busy1, busy2, busy3;
    logic       done0, done1, done2, done3;
    logic [7:0] r0, r1, r3;
    logic [15:0] r2;
    logic       cout0, cout1, cout2, cout3;
    logic       ovf0, ovf1, ovf2, ovf3;
    logic       zero0, zero1, zero2, zero3;

    logic [15:0] res_o  [4];
    logic        busy_o [4];
    logic        done_o [4];
    logic        cout_o [4];
    logic        ovf_o  [4];
    logic        zero_o [4];

    exp_t sb_q [4][$];

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .result(r0), .cout(cout0), .ovf(ovf0), .zero(zero0));
    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(r1), .cout(cout1), .ovf(ovf1), .zero(zero1));
    serial_addsub #(.WIDTH(16), .DIGIT(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(r2), .cout(cout2), .ovf(ovf2), .zero(zero2));
    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .result(r3), .cout(cout3), .ovf(ovf3), .zero(zero3));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        res_o[0] = {8'h00, r0}; res_o[1] = {8'h00, r1}; res_o[2] = r2; res_o[3] = {8'h00, r3};
        busy_o[0] = busy0; busy_o[1] = busy1; busy_o[2] = busy2; busy_o[3] = busy3;
        done_o[0] = done0; done_o[1] = done1; done_o[2] = done2; done_o[3] = done3;
        cout_o[0] = cout0; cout_o[1] = cout1; cout_o[2] = cout2; cout_o[3] = cout3;
        ovf_o[0]  = ovf0;  ovf_o[1]  = ovf1;  ovf_o[2]  = ovf2;  ovf_o[3]  = ovf3;
        zero_o[0] = zero0; zero_o[1] = zero1; zero_o[2] = zero2; zero_o[3] = zero3;
    end

    task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cfg%0d: got %h expected %h (cycle %0d)", name, k, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(logic [15:0] r, logic c, logic o, logic z);
        exp_t e;
        e.res = r; e.c = c; e.o = o; e.z = z; e.due = 0;
        return e;
    endfunction

    // Whole-word reference: a +/- b modulo 2^w with carry/borrow and signed overflow.
    function automatic exp_t model(int w, logic md, logic [15:0] av, logic [15:0] bv);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] mask;
        logic        sa, sb, sr;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        full = md ? ({1'b0, av} - {1'b0, bv}) : ({1'b0, av} + {1'b0, bv});
        e.res = full[15:0] & mask;
        e.c   = md ? (av < bv) : ((w == 16) ? full[16] : full[8]);
        sa = (w == 16) ? av[15] : av[7];
        sb = (w == 16) ? bv[15] : bv[7];
        sr = (w == 16) ? e.res[15] : e.res[7];
        e.o   = md ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        e.z   = (e.res == 16'h0000);
        e.due = 0;
        return e;
    endfunction

    task automatic drive(int k, logic st, logic md, logic [15:0] av, logic [15:0] bv);
        case (k)
            0: begin start0 = st; mode0 = md; a0 = av[7:0]; b0 = bv[7:0]; end
            1: begin start1 = st; mode1 = md; a1 = av[7:0]; b1 = bv[7:0]; end
            2: begin start2 = st; mode2 = md; a2 = av;      b2 = bv;      end
            default: begin start3 = st; mode3 = md; a3 = av[7:0]; b3 = bv[7:0]; end
        endcase
    endtask

    // Wait for idle, pulse start for one edge and queue the expected completion.
    task automatic issue(int k, logic md, logic [15:0] av, logic [15:0] bv, exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy_o[k]) begin
            failures++;
            $display("FAIL idle_timeout cfg%0d: busy still 1 after %0d cycles, required 0", k, n);
        end
        drive(k, 1'b1, md, av, bv);
        @(posedge clk);
        #1;
        drive(k, 1'b0, md, av, bv);
        chk("busy_after_start", k, {31'd0, busy_o[k]}, 32'd1);
        e.due = cyc + N_OF[k];
        sb_q[k].push_back(e);
    endtask

    task automatic drain(int k);
        int n;
        n = 0;
        while (sb_q[k].size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q[k].size() != 0) begin
            failures++;
            $display("FAIL drain_timeout cfg%0d: %0d ops pending, required 0", k, sb_q[k].size());
        end
    endtask

    task automatic chk_all_zero(string name, int k);
        chk(name, k, {10'd0, res_o[k], busy_o[k], done_o[k], cout_o[k], ovf_o[k], zero_o[k]}, 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (busy_o[k] && done_o[k]) begin
                failures++;
                $display("FAIL busy_and_done cfg%0d: both 1 at cycle %0d, required not both", k, cyc);
            end
            if (done_o[k]) begin
                if (sb_q[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done cfg%0d: done 1 at cycle %0d, required no pending op", k, cyc);
                end else begin
                    e = sb_q[k].pop_front();
                    chk("result", k, {16'd0, res_o[k]}, {16'd0, e.res});
                    chk("cout",   k, {31'd0, cout_o[k]}, {31'd0, e.c});
                    chk("ovf",    k, {31'd0, ovf_o[k]},  {31'd0, e.o});
                    chk("zero",   k, {31'd0, zero_o[k]}, {31'd0, e.z});
                    chk("done_cycle", k, cyc, e.due);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic        md;
        logic [15:0] av, bv, mask;

        for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk_all_zero("reset_state", k);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic on 8/1.
        issue(0, 1'b1, 16'h05, 16'h03, mk(16'h02, 1'b0, 1'b0, 1'b0));
        issue(0, 1'b1, 16'h03, 16'h05, mk(16'hFE, 1'b1, 1'b0, 1'b0));
        issue(0, 1'b1, 16'h80, 16'h01, mk(16'h7F, 1'b0, 1'b1, 1'b0));
        issue(0, 1'b0, 16'hFF, 16'h01, mk(16'h00, 1'b1, 1'b0, 1'b1));
        issue(0, 1'b0, 16'h7F, 16'h01, mk(16'h80, 1'b0, 1'b1, 1'b0));
        drain(0);

        // Handshake: ignored start mid-run, then start held high into done.
        issue(0, 1'b1, 16'h10, 16'h01, mk(16'h0F, 1'b0, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'h00, 16'h01);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 16'h00, 16'h01);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h22, 16'h11);
        n = 0;
        while (!done_o[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen_handshake", 0, {31'd0, done_o[0]}, 32'd1);
        @(posedge clk);
        #1;
        chk("busy_backtoback", 0, {30'd0, busy_o[0], done_o[0]}, 32'd2);
        begin
            exp_t e2;
            e2 = mk(16'h33, 1'b0, 1'b0, 1'b0);
            e2.due = cyc + N_OF[0];
            sb_q[0].push_back(e2);
        end
        drive(0, 1'b0, 1'b0, 16'h22, 16'h11);
        drain(0);

        // Reset during cycle 4 of a run: abort with no done pulse.
        issue(0, 1'b1, 16'h55, 16'h22, mk(16'h33, 1'b0, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb_q[0].delete();
        chk_all_zero("reset_midop", 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_all_zero("no_done_after_reset", 0);
        issue(0, 1'b0, 16'h40, 16'h40, mk(16'h80, 1'b0, 1'b1, 1'b0));
        drain(0);

        // Directed boundary vectors on the wider-digit configurations.
        issue(1, 1'b0, 16'h7F, 16'h01, mk(16'h80, 1'b0, 1'b1, 1'b0));
        issue(2, 1'b0, 16'h8000, 16'h8000, mk(16'h0000, 1'b1, 1'b1, 1'b1));
        issue(3, 1'b1, 16'h00, 16'h01, mk(16'hFF, 1'b1, 1'b0, 1'b0));
        drain(1); drain(2); drain(3);

        // Random sweep on every configuration against the whole-word model.
        for (int k = 0; k < 4; k++) begin
            mask = (W_OF[k] == 16) ? 16'hFFFF : 16'h00FF;
            for (int i = 0; i < 1000; i++) begin
                md = 1'($urandom_range(0, 1));
                av = 16'($urandom) & mask;
                bv = 16'($urandom) & mask;
                issue(k, md, av, bv, model(W_OF[k], md, av, bv));
            end
            drain(k);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
